// File: rtl/datapath_pkg.sv
// Shared widths, instruction field positions and branch-offset helper for the fetch/register slice.
// Pure definitions: no latency, no flow control.
package datapath_pkg;
   localparam int DATA_W  = 32;
   localparam int REG_AW  = 5;
   localparam int RS_LSB  = 21;
   localparam int RT_LSB  = 16;
   localparam int RD_LSB  = 11;
   localparam int IMM_LSB = 0;
   localparam int IMM_W   = 16;
   localparam logic [DATA_W-1:0] PC_STEP = 32'd4;

   // Branch offsets count words, so the sign-extended immediate is scaled by 4.
   function automatic logic [DATA_W-1:0] f_br_offset(input logic [IMM_W-1:0] imm);
      return {{(DATA_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
   endfunction
endpackage

// File: rtl/datapath_if.sv
// Control/ALU-side handshake bundle of the datapath slice; master is the control unit, slave the datapath.
// Plain wires: no latency, no flow control.
interface datapath_if;
   import datapath_pkg::*;

   logic              br;
   logic              zf;
   logic              regdst;
   logic              enable;
   logic [DATA_W-1:0] datos_esc;
   logic [DATA_W-1:0] s1;
   logic [DATA_W-1:0] s2;

   modport master (output br, zf, regdst, enable, datos_esc, input s1, s2);
   modport slave  (input br, zf, regdst, enable, datos_esc, output s1, s2);
endinterface

// File: rtl/datapath_imem.sv
// Instruction ROM, read combinationally by word index; contents are preloaded externally, never reset.
// Zero latency, no flow control.
module datapath_imem
   import datapath_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic [$clog2(DEPTH)-1:0] i_addr,
   output logic [DATA_W-1:0]        o_dat
);
   logic [DATA_W-1:0] MR [DEPTH];

   assign o_dat = MR[i_addr];
endmodule

// File: rtl/datapath_reg_file.sv
// Register file, two combinational read ports and one write port; r0 always reads zero and ignores writes.
// Reads zero latency (no bypass), writes land on the clock edge; no flow control, contents survive reset.
module reg_file
   import datapath_pkg::*;
#(
   parameter int DEPTH = 32
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdat,
   input  logic [REG_AW-1:0] i_raddr1,
   input  logic [REG_AW-1:0] i_raddr2,
   output logic [DATA_W-1:0] o_rdat1,
   output logic [DATA_W-1:0] o_rdat2
);
   logic [DATA_W-1:0] mem [DEPTH];

   // No reset on purpose: preloaded register contents must survive a PC reset.
   always_ff @(posedge clk) begin
      if (i_we && (i_waddr != '0)) begin
         mem[i_waddr] <= i_wdat;
      end
   end

   assign o_rdat1 = (i_raddr1 == '0) ? '0 : mem[i_raddr1];
   assign o_rdat2 = (i_raddr2 == '0) ? '0 : mem[i_raddr2];
endmodule

// File: rtl/datapath.sv
// Fetch/decode/register-read slice: PC, next-PC/branch logic, instruction ROM and register file.
// Operands combinational from PC; PC and register writes update in one clock; no backpressure.
module datapath
   import datapath_pkg::*;
#(
   parameter int IMEM_DEPTH = 64,
   parameter int RF_DEPTH   = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   datapath_if.slave bus
);
   localparam int IA_W = $clog2(IMEM_DEPTH);

   logic [DATA_W-1:0] r_pc;
   logic [DATA_W-1:0] w_instr;
   logic [DATA_W-1:0] w_pc_inc;
   logic [DATA_W-1:0] w_pc_nxt;
   logic [REG_AW-1:0] w_rs;
   logic [REG_AW-1:0] w_rt;
   logic [REG_AW-1:0] w_rd;
   logic [REG_AW-1:0] w_waddr;
   logic [IMM_W-1:0]  w_imm;
   logic              w_taken;
   logic              w_unused_opc;

   datapath_imem #(.DEPTH(IMEM_DEPTH)) p3 (
      .i_addr (r_pc[IA_W+1:2]),
      .o_dat  (w_instr)
   );

   assign w_rs         = w_instr[RS_LSB +: REG_AW];
   assign w_rt         = w_instr[RT_LSB +: REG_AW];
   assign w_rd         = w_instr[RD_LSB +: REG_AW];
   assign w_imm        = w_instr[IMM_LSB +: IMM_W];
   assign w_unused_opc = ^w_instr[DATA_W-1:RS_LSB+REG_AW];

   assign w_waddr  = bus.regdst ? w_rd : w_rt;
   assign w_taken  = bus.br & bus.zf;
   assign w_pc_inc = r_pc + PC_STEP;
   assign w_pc_nxt = w_taken ? (w_pc_inc + f_br_offset(w_imm)) : w_pc_inc;

   reg_file #(.DEPTH(RF_DEPTH)) p7 (
      .clk      (clk),
      .i_we     (bus.enable),
      .i_waddr  (w_waddr),
      .i_wdat   (bus.datos_esc),
      .i_raddr1 (w_rs),
      .i_raddr2 (w_rt),
      .o_rdat1  (bus.s1),
      .o_rdat2  (bus.s2)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= '0;
      end else begin
         r_pc <= w_pc_nxt;
      end
   end
endmodule

// File: tb/tb_datapath.sv
// Directed bench for the datapath slice: vector table for the main program plus hand sequences
// for async reset, branch corners, read-during-write and fetch wrap.
module tb_datapath;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   datapath_if bus ();

   datapath DUV (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        br;
      logic        zf;
      logic        regdst;
      logic        enable;
      logic [31:0] dat;
      logic [31:0] pc;
      logic [31:0] s1;
      logic [31:0] s2;
   } vec_t;

   vec_t tbl [12];

   function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd);
      return {6'd0, rs[4:0], rt[4:0], rd[4:0], 11'd0};
   endfunction

   function automatic logic [31:0] mk_i(input int rs, input int rt, input logic [15:0] imm);
      return {6'd4, rs[4:0], rt[4:0], imm};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic br, input logic zf, input logic regdst,
                        input logic en, input logic [31:0] dat);
      bus.br        = br;
      bus.zf        = zf;
      bus.regdst    = regdst;
      bus.enable    = en;
      bus.datos_esc = dat;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 64; i++) DUV.p3.MR[i] = 32'd0;
      #1 rst_n = 1'b0;
      #1;
      check("reset_pc", DUV.r_pc, 32'd0);
      check("reset_s1_r0", bus.s1, 32'd0);

      // Preload r16..r31 = 16..31 through the write port, one rd per instruction.
      for (int i = 0; i < 16; i++) DUV.p3.MR[i] = mk_r(0, 0, 16 + i);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 32'(16 + i));
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      check("preload_pc", DUV.r_pc, 32'd64);
      rst_n = 1'b0;
      #1;
      check("async_rst_pc0", DUV.r_pc, 32'd0);

      // Main program.
      for (int i = 0; i < 64; i++) DUV.p3.MR[i] = 32'd0;
      DUV.p3.MR[0]  = mk_r(17, 18, 20);
      DUV.p3.MR[1]  = mk_r(20, 19, 20);
      DUV.p3.MR[2]  = mk_r(20, 21, 22);
      DUV.p3.MR[3]  = mk_r(21, 22, 0);
      DUV.p3.MR[4]  = mk_r(0, 0, 24);
      DUV.p3.MR[5]  = mk_r(0, 24, 25);
      DUV.p3.MR[6]  = mk_r(25, 20, 0);
      DUV.p3.MR[7]  = mk_i(20, 25, 16'h0003);
      DUV.p3.MR[11] = mk_r(26, 27, 0);
      DUV.p3.MR[12] = mk_i(28, 29, 16'hFFFF);
      DUV.p3.MR[13] = mk_r(30, 31, 0);
      DUV.p3.MR[14] = mk_r(31, 16, 0);
      #1;
      check("rst_s1_mr0_nclk", bus.s1, 32'd17);
      check("rst_s2_mr0_nclk", bus.s2, 32'd18);

      //            br    zf    rdst  en    dat            pc      s1     s2
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd4,        32'd4,  32'd4,  32'd19};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd8,        32'd8,  32'd8,  32'd21};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd55,       32'd12, 32'd55, 32'd22};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd99,       32'd16, 32'd0,  32'd0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd77,       32'd20, 32'd0,  32'd24};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'd24, 32'd25, 32'd8};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678, 32'd28, 32'd8,  32'd25};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0,        32'd44, 32'd26, 32'd27};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0,        32'd48, 32'd28, 32'd29};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0,        32'd48, 32'd28, 32'd29};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0,        32'd52, 32'd30, 32'd31};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        32'd56, 32'd31, 32'd16};

      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].br, tbl[i].zf, tbl[i].regdst, tbl[i].enable, tbl[i].dat);
         tick();
         check($sformatf("vec%0d_pc", i), DUV.r_pc, tbl[i].pc);
         check($sformatf("vec%0d_s1", i), bus.s1, tbl[i].s1);
         check($sformatf("vec%0d_s2", i), bus.s2, tbl[i].s2);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

      // Async reset mid-cycle; register contents must survive.
      #3 rst_n = 1'b0;
      #1;
      check("midcyc_rst_pc", DUV.r_pc, 32'd0);
      check("midcyc_rst_r17", bus.s1, 32'd17);
      DUV.p3.MR[0] = mk_i(20, 21, 16'h0003);
      #1;
      check("retain_r20", bus.s1, 32'd8);
      check("retain_r21", bus.s2, 32'd55);
      rst_n = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      check("br_taken_pc", DUV.r_pc, 32'h10);

      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      check("br_not_taken_pc", DUV.r_pc, 32'd4);
      DUV.p3.MR[1] = mk_r(0, 0, 0);
      DUV.p3.MR[2] = mk_i(31, 30, 16'hFFFF);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      check("seq_pc8", DUV.r_pc, 32'd8);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      check("br_self_pc", DUV.r_pc, 32'd8);
      check("br_self_s1", bus.s1, 32'd31);
      check("br_self_s2", bus.s2, 32'd30);

      // Read-during-write: imm FFFF puts rd=31 and keeps the PC in place.
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'd500);
      #1;
      check("rdw_old_s1", bus.s1, 32'd31);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      check("rdw_pc", DUV.r_pc, 32'd8);
      check("rdw_new_s1", bus.s1, 32'd500);
      check("rdw_s2", bus.s2, 32'd30);

      // Branch to PC=256 wraps the fetch index back to word 0.
      rst_n = 1'b0;
      DUV.p3.MR[0] = mk_i(20, 21, 16'd63);
      #1 rst_n = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      check("wrap_pc", DUV.r_pc, 32'd256);
      check("wrap_s1", bus.s1, 32'd8);
      check("wrap_s2", bus.s2, 32'd55);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
